// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr N-to-1 stream multiplexer:
// arbitration mode encodings and the channel-index width helper.
package stream_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Width of a channel index: max(1, clog2(n)).
    function automatic int ch_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter for stream_mux_rr.
// Round-robin searches from ptr upwards with wrap; fixed priority picks the
// lowest requesting index. While lock_en is high only lock_ch may be granted.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int MODE = MODE_RR,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            lock_en,
    input  logic [CH_W-1:0] lock_ch,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    logic found_s;
    int   idx_s;

    // Pick at most one requester; grant stays one-hot or all-zero.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        if (lock_en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (i == int'(lock_ch)) begin
                    grant[i] = req[i];
                end else begin
                    grant[i] = 1'b0;
                end
            end
            grant_idx = lock_ch;
        end else if (MODE == MODE_FIXED) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found_s && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                    found_s   = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                idx_s = (int'(ptr) + i) % N_CH;
                if (!found_s && req[idx_s]) begin
                    grant[idx_s] = 1'b1;
                    grant_idx    = CH_W'(idx_s);
                    found_s      = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel to 1 valid/ready stream multiplexer with an internal arbiter
// (round-robin or fixed priority) and a single registered output stage.
// in_ready depends combinationally on out_ready through load_en; this keeps
// full throughput with one output register.
// Optional build macro STREAM_MUX_PACKET_LOCK_EN: holds the grant on a
// channel from its first non-last beat until its last beat is accepted.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    parameter  int MODE  = MODE_RR,
    localparam int CH_W  = ch_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [CH_W-1:0]  out_ch_r;
    logic [CH_W-1:0]  ptr_r;

    logic [N_CH-1:0]  grant_s;
    logic [CH_W-1:0]  grant_idx_s;
    logic [N_CH-1:0]  in_ready_s;
    logic             load_en_s;
    logic             xfer_in_s;
    logic             lock_en_s;
    logic [CH_W-1:0]  lock_ch_s;
    logic             ptr_adv_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_last_s;

    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_r),
        .lock_en   (lock_en_s),
        .lock_ch   (lock_ch_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign load_en_s  = !out_valid_r | out_ready;
    assign in_ready_s = grant_s & {N_CH{load_en_s & !rst}};
    assign xfer_in_s  = |in_ready_s;
    assign sel_last_s = |(in_last & grant_s);

    // Mux the granted channel's data using the one-hot grant.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

`ifdef STREAM_MUX_PACKET_LOCK_EN
    logic            lock_active_r;
    logic [CH_W-1:0] lock_ch_r;

    assign lock_en_s = lock_active_r;
    assign lock_ch_s = lock_ch_r;
    assign ptr_adv_s = xfer_in_s & sel_last_s;

    // Lock onto a channel after a non-last beat, release on its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active_r <= 1'b0;
            lock_ch_r     <= '0;
        end else if (xfer_in_s) begin
            lock_active_r <= !sel_last_s;
            lock_ch_r     <= grant_idx_s;
        end else begin
            lock_active_r <= lock_active_r;
            lock_ch_r     <= lock_ch_r;
        end
    end
`else
    assign lock_en_s = 1'b0;
    assign lock_ch_s = '0;
    assign ptr_adv_s = xfer_in_s;
`endif

    // Round-robin pointer moves just past the channel that was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if ((MODE == MODE_RR) && ptr_adv_s) begin
            if (int'(grant_idx_s) == N_CH - 1) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_idx_s + CH_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Output stage: load on input transfer, clear valid on bare drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_ch_r    <= '0;
        end else if (xfer_in_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_last_r  <= sel_last_s;
            out_ch_r    <= (N_CH == 1) ? '0 : grant_idx_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: one round-robin and one fixed-priority
// instance. Stimulus pushes hand-computed beats; negedge monitors pop and
// compare each output transfer. Packet expectations follow
// STREAM_MUX_PACKET_LOCK_EN.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_valid_fx;
    logic [3:0]  in_last;
    logic        out_ready;

    logic [3:0]  rr_in_ready, fx_in_ready;
    logic [7:0]  rr_out_data, fx_out_data;
    logic        rr_out_valid, fx_out_valid;
    logic        rr_out_last, fx_out_last;
    logic [1:0]  rr_out_ch, fx_out_ch;

    beat_t exp_rr[$];
    beat_t exp_fx[$];
    int    checks = 0;
    int    failures = 0;
    logic [7:0] pkt_data [3];
    int    b;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(MODE_RR)) dut_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rr_in_ready), .out_data(rr_out_data),
        .out_valid(rr_out_valid), .out_last(rr_out_last), .out_ch(rr_out_ch),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(MODE_FIXED)) dut_fx (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_fx),
        .in_last(in_last), .in_ready(fx_in_ready), .out_data(fx_out_data),
        .out_valid(fx_out_valid), .out_last(fx_out_last), .out_ch(fx_out_ch),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rr(input logic [1:0] ch, input logic last, input logic [7:0] data);
        beat_t e;
        e.ch = ch; e.last = last; e.data = data;
        exp_rr.push_back(e);
    endtask

    task automatic push_fx(input logic [1:0] ch, input logic last, input logic [7:0] data);
        beat_t e;
        e.ch = ch; e.last = last; e.data = data;
        exp_fx.push_back(e);
    endtask

    // Monitor: every output transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rr_out_valid && out_ready) begin
            if (exp_rr.size() == 0) begin
                checks++; failures++;
                $display("FAIL rr_unexpected_beat: got ch=%0d data=0x%0h expected none", rr_out_ch, rr_out_data);
            end else begin
                chk("rr_beat{ch,last,data}", 32'({rr_out_ch, rr_out_last, rr_out_data}), 32'(exp_rr.pop_front()));
            end
        end
        if (!rst && fx_out_valid && out_ready) begin
            if (exp_fx.size() == 0) begin
                checks++; failures++;
                $display("FAIL fx_unexpected_beat: got ch=%0d data=0x%0h expected none", fx_out_ch, fx_out_data);
            end else begin
                chk("fx_beat{ch,last,data}", 32'({fx_out_ch, fx_out_last, fx_out_data}), 32'(exp_fx.pop_front()));
            end
        end
    end

    // Watchdog bounding the whole run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 4'hF; in_valid_fx = 4'h0; in_last = 4'hF;
        in_data = 32'h13121110; out_ready = 1'b1;
        pkt_data[0] = 8'hB1; pkt_data[1] = 8'hB2; pkt_data[2] = 8'hB3;

        // Reset held three cycles with every channel valid.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_in_ready", 32'(rr_in_ready), 32'h0);
        end
        chk("reset_out_valid", 32'(rr_out_valid), 32'h0);
        chk("reset_out_ch", 32'(rr_out_ch), 32'h0);
        chk("reset_out_data", 32'(rr_out_data), 32'h0);
        rst = 1'b0; #1;
        chk("first_grant", 32'(rr_in_ready), 32'h1);
        push_rr(2'd0, 1'b1, 8'h10);
        step(); in_valid = 4'h0;
        chk("first_out_valid", 32'(rr_out_valid), 32'h1);
        chk("first_out_ch", 32'(rr_out_ch), 32'h0);
        step();
        chk("first_drain", 32'(rr_out_valid), 32'h0);

        // Single beat on ch2 (ptr now 1).
        in_data[23:16] = 8'hA5; in_valid = 4'b0100;
        push_rr(2'd2, 1'b1, 8'hA5);
        step(); in_valid = 4'h0;
        chk("single_valid", 32'(rr_out_valid), 32'h1);
        chk("single_data", 32'(rr_out_data), 32'hA5);
        chk("single_ch", 32'(rr_out_ch), 32'h2);
        step();
        chk("single_drain", 32'(rr_out_valid), 32'h0);
        chk("drain_hold_data", 32'(rr_out_data), 32'hA5);
        in_data[23:16] = 8'h12;

        // ptr is 3; load ch3 then reset while it is pending.
        in_valid = 4'hF; #1;
        chk("ptr3_grant", 32'(rr_in_ready), 32'h8);
        step(); rst = 1'b1;
        step();
        chk("midop_reset_valid", 32'(rr_out_valid), 32'h0);
        rst = 1'b0; #1;
        chk("post_reset_grant", 32'(rr_in_ready), 32'h1);

        // Round-robin with all four valid: 0,1,2,3,0,1 back to back.
        push_rr(2'd0, 1'b1, 8'h10); push_rr(2'd1, 1'b1, 8'h11);
        push_rr(2'd2, 1'b1, 8'h12); push_rr(2'd3, 1'b1, 8'h13);
        push_rr(2'd0, 1'b1, 8'h10); push_rr(2'd1, 1'b1, 8'h11);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_no_bubble", 32'(rr_out_valid), 32'h1);
        end
        in_valid = 4'h0;
        step();
        chk("rr_drain", 32'(rr_out_valid), 32'h0);

        // ch1 dropped: 0,2,3,0 from a fresh pointer.
        rst = 1'b1; step(); rst = 1'b0;
        in_valid = 4'b1101;
        push_rr(2'd0, 1'b1, 8'h10); push_rr(2'd2, 1'b1, 8'h12);
        push_rr(2'd3, 1'b1, 8'h13); push_rr(2'd0, 1'b1, 8'h10);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("skip_no_bubble", 32'(rr_out_valid), 32'h1);
        end
        in_valid = 4'h0;
        step();
        chk("skip_drain", 32'(rr_out_valid), 32'h0);

        // Backpressure: ptr is 1, ch1 held for five cycles, then ch2 follows.
        in_valid = 4'hF;
        push_rr(2'd1, 1'b1, 8'h11); push_rr(2'd2, 1'b1, 8'h12);
        step(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(rr_out_valid), 32'h1);
            chk("bp_ch", 32'(rr_out_ch), 32'h1);
            chk("bp_data", 32'(rr_out_data), 32'h11);
            chk("bp_in_ready", 32'(rr_in_ready), 32'h0);
        end
        out_ready = 1'b1; #1;
        chk("bp_release_grant", 32'(rr_in_ready), 32'h4);
        step(); in_valid = 4'h0;
        chk("bp_next_valid", 32'(rr_out_valid), 32'h1);
        chk("bp_next_ch", 32'(rr_out_ch), 32'h2);
        step();
        chk("bp_drain", 32'(rr_out_valid), 32'h0);

        // Fixed priority: ch1 beats ch3, then ch3 once ch1 leaves.
        in_valid_fx = 4'b1010; #1;
        chk("fx_grant", 32'(fx_in_ready), 32'h2);
        push_fx(2'd1, 1'b1, 8'h11); push_fx(2'd1, 1'b1, 8'h11); push_fx(2'd1, 1'b1, 8'h11);
        push_fx(2'd3, 1'b1, 8'h13);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fx_ch1", 32'(fx_out_ch), 32'h1);
        end
        in_valid_fx = 4'b1000;
        step();
        chk("fx_ch3", 32'(fx_out_ch), 32'h3);
        in_valid_fx = 4'h0;
        step();
        chk("fx_drain", 32'(fx_out_valid), 32'h0);

        // Packet: ch0 sends 3 beats (last on third) while ch2 stays valid.
        rst = 1'b1; step(); rst = 1'b0;
        in_data[23:16] = 8'h22;
        b = 0;
`ifdef STREAM_MUX_PACKET_LOCK_EN
        push_rr(2'd0, 1'b0, 8'hB1); push_rr(2'd0, 1'b0, 8'hB2);
        push_rr(2'd0, 1'b1, 8'hB3); push_rr(2'd2, 1'b1, 8'h22);
        for (int c = 0; c < 4; c++) begin
`else
        push_rr(2'd0, 1'b0, 8'hB1); push_rr(2'd2, 1'b1, 8'h22);
        push_rr(2'd0, 1'b0, 8'hB2); push_rr(2'd2, 1'b1, 8'h22);
        push_rr(2'd0, 1'b1, 8'hB3);
        for (int c = 0; c < 5; c++) begin
`endif
            if (b < 3) begin
                in_data[7:0] = pkt_data[b];
                in_last[0] = (b == 2);
                in_valid = 4'b0101;
            end else begin
                in_valid = 4'b0100;
            end
            #1;
            if (in_valid[0] && rr_in_ready[0]) b++;
            step();
        end
        in_valid = 4'h0;
        step();
        chk("pkt_drain", 32'(rr_out_valid), 32'h0);
        chk("pkt_beats_sent", 32'(b), 32'h3);

        chk("rr_queue_empty", 32'(exp_rr.size()), 32'h0);
        chk("fx_queue_empty", 32'(exp_fx.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
